dst40_scheduler: RTL
====================

# dst40_scheduler

Search sequencer for one `dst40_XX` key-search array. It enumerates every key in a 40-bit range that matches a 24-bit response, not just the first. Each hit is a candidate; the block decodes it into full 40-bit keys and queues them to the host through a valid/ready FIFO. It then restarts the array just past the hit and repeats until the keyspace is exhausted.

## Interface
Parameters:
- `NK`, 2: kernel count of the attached `dst40_XX`.
- `L2NK`, 1: log2(`NK`).
- `LOW_CYCLES`, 4: cycles `dst_run_o` is held low before each (re)start; legal range is 3 or more.
- `FIFO_DEPTH`, 8: candidate FIFO entries; must be a power of 2.

Ports:
- `clock_i` in 1: clock.
- `reset_n_i` in 1: **one clock; reset is asynchronous and active-low.**
- `start_i` in 1: one-cycle start pulse; honoured in IDLE and DONE only.
- `abort_i` in 1: level; forces IDLE.
- `challenge_i` in 40: challenge, latched at start.
- `response_i` in 24: response, latched at start.
- `start_key_i` in 40: first key; only bits [39-L2NK:0] are used.
- `dst_challenge_o` out 40: to the array.
- `dst_response_o` out 24: to the array.
- `dst_start_key_o` out 40: to the array; bits [39:40-L2NK] are always 0.
- `dst_run_o` out 1: run enable to the array.
- `dst_key_found_i` in 1: found flag from the array.
- `dst_key_not_found_i` in 1: exhausted flag from the array.
- `dst_kernels_i` in NK: per-kernel hit bits from the array.
- `dst_key_i` in 40-L2NK: low key bits from the array.
- `cand_valid_o` out 1: candidate available.
- `cand_ready_i` in 1: host accepts the candidate.
- `cand_key_o` out 40: full candidate key.
- `busy_o` out 1: 1 whenever the state is not IDLE and not DONE.
- `done_o` out 1: keyspace exhausted.
- `cand_count_o` out 16: candidates found; see Configuration.

## Operation
- **IDLE**
  - On `start_i`: latch challenge, response and `start_key_i[39-L2NK:0]` into `next_low`. Flush the FIFO, clear `cand_count_o`, go to LOAD.
- **LOAD**
  - `dst_run_o`=0 and `dst_start_key_o`={0, `next_low`}.
  - A counter runs 0..LOW_CYCLES-1, then the state goes to RUN.
  - This guarantees the array's 2-flop run synchroniser sees low and reloads its registers.
- **RUN**
  - `dst_run_o`=1.
  - If `dst_key_found_i`: capture `dst_kernels_i` into `mask` and `dst_key_i` into `hit_low`, go to EMIT.
  - Else if `dst_key_not_found_i`: go to DONE.
  - Found has priority when both flags are high.
- **EMIT**
  - `dst_run_o`=0.
  - Each cycle the FIFO is not full: push {i[L2NK-1:0], `hit_low`} for the lowest set bit i of `mask`, then clear that bit.
  - When `mask` is 0:
    - If `hit_low` is all ones, go to DONE (no wrap).
    - Otherwise set `next_low`=`hit_low`+1 (width 40-L2NK) and go to LOAD.
- **DONE**
  - `done_o`=1 and `dst_run_o`=0.
  - The FIFO keeps draining.
  - `start_i` restarts exactly as from IDLE.
- **`abort_i`** (any state): go to IDLE next cycle, `dst_run_o`=0, flush the FIFO.
- **`start_i` outside IDLE/DONE**: ignored.
- **FIFO**
  - A pop happens when `cand_valid_o && cand_ready_i`.
  - Push and pop may occur in the same cycle, including when the FIFO is full (the pop frees the slot).
  - Order is first-in first-out; no candidate is ever dropped. EMIT stalls instead.

## Timing
- **Reset values:**
  - state IDLE;
  - all outputs 0, including `dst_run_o`, `cand_valid_o`, `busy_o`, `done_o`, `cand_count_o`, `dst_*` data.
- **All outputs are registered.**
- **Run low time:** `dst_run_o` falls the cycle after a hit or exhaustion flag is sampled, and stays low for at least LOW_CYCLES cycles before rising again.
- **Latency:**
  - found sampled to first push: 1 cycle;
  - push to `cand_valid_o`: 1 cycle.
- **Flag qualification:** `dst_key_*_i` is sampled only in RUN. Flags seen in LOAD, EMIT or DONE are ignored.

## Configuration
- `DST40_SCHED_COUNT_EN`
  - **Defined:** `cand_count_o` counts pushed candidates. It saturates at 0xFFFF and clears on start and abort.
  - **Undefined:** the counter is not built and `cand_count_o` is constant 0.

## Structure
- **Package `dst40_sched_pkg`:** state enum (IDLE, LOAD, RUN, EMIT, DONE), the LOW_CYCLES default, and the key-width constant.
- **Sub-module `dst40_cand_fifo`:** parameterised synchronous FIFO (width 40, depth FIFO_DEPTH) with full/empty flags and a flush input.
- **Priority encoder:** a function inside the top module.

## Test plan
Benches use NK=2 and L2NK=1, with a scripted stub standing in for the array.
1. Start with `start_key_i`=0; stub returns found, kernels=2'b10, key=0x12_3456_789A.
   - Candidate is 0x92_3456_789A.
   - Relaunch with `dst_start_key_o`=0x12_3456_789B after `dst_run_o` has been low for 4 cycles or more.
2. Kernels=2'b11, key=0x00_0000_0005.
   - Two candidates in order: 0x00_0000_0005, then 0x80_0000_0005.
3. Kernels=2'b01, key=0x7F_FFFF_FFFF.
   - One candidate 0x7F_FFFF_FFFF.
   - `done_o`=1; `dst_run_o` never rises again.
4. Stub asserts not_found in RUN.
   - `done_o`=1 and `dst_run_o`=0 one cycle later.
   - `busy_o`=0.
5. Hold `cand_ready_i`=0; stub returns 5 hits, each with kernels=2'b11.
   - EMIT stalls at 8 entries with run low.
   - Release ready: all 10 keys appear in order.
   - `cand_count_o`=10 when the macro is defined.
6. Assert `abort_i` mid-RUN, then `reset_n_i` low mid-EMIT.
   - IDLE with `dst_run_o`=0 and the FIFO empty.
   - After reset, all outputs are 0 immediately, asynchronously.

Source files
------------

// File: rtl/dst40_sched_pkg.sv
// Shared types and constants for the dst40 key-search scheduler.
// State encoding, key width and default run-low hold time.
package dst40_sched_pkg;

  localparam int KEY_W          = 40;
  localparam int LOW_CYCLES_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_EMIT,
    S_DONE
  } state_t;

endpackage

// File: rtl/dst40_cand_fifo.sv
// Candidate FIFO with a synchronous flush; a push is visible on vld one cycle later.
// When full it still takes a push in the same cycle as a pop; otherwise the writer must stall.
module dst40_cand_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 8
) (
  input  logic         clock_i,
  input  logic         reset_n_i,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         vld
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          wr_en, rd_en;

  assign rd_en   = pop && vld;
  assign wr_en   = push && (!full || rd_en);
  assign pop_dat = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (wr_en && !rd_en)
      count_nxt = count + 1'b1;
    else if (!wr_en && rd_en)
      count_nxt = count - 1'b1;
  end

  // Occupancy flags are registered so vld/full drive ports straight from flops.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld    <= 1'b0;
      full   <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld    <= 1'b0;
      full   <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      vld   <= (count_nxt != '0);
      full  <= (count_nxt == (AW+1)'(DEPTH));
    end
  end

endmodule

// File: rtl/dst40_scheduler.sv
// Enumerates every matching key of a dst40 array; found-to-push 1 cycle, push-to-valid 1 cycle.
// EMIT stalls while the candidate FIFO is full; DST40_SCHED_COUNT_EN builds the candidate counter.
module dst40_scheduler
  import dst40_sched_pkg::*;
#(
  parameter int NK         = 2,
  parameter int L2NK       = 1,
  parameter int LOW_CYCLES = LOW_CYCLES_DEF,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                   clock_i,
  input  logic                   reset_n_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [KEY_W-1:0]       challenge_i,
  input  logic [23:0]            response_i,
  input  logic [KEY_W-1:0]       start_key_i,
  output logic [KEY_W-1:0]       dst_challenge_o,
  output logic [23:0]            dst_response_o,
  output logic [KEY_W-1:0]       dst_start_key_o,
  output logic                   dst_run_o,
  input  logic                   dst_key_found_i,
  input  logic                   dst_key_not_found_i,
  input  logic [NK-1:0]          dst_kernels_i,
  input  logic [KEY_W-L2NK-1:0]  dst_key_i,
  output logic                   cand_valid_o,
  input  logic                   cand_ready_i,
  output logic [KEY_W-1:0]       cand_key_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [15:0]            cand_count_o
);

  localparam int LW  = KEY_W - L2NK;
  localparam int LCW = $clog2(LOW_CYCLES);

  function automatic logic [L2NK-1:0] lowest_idx(input logic [NK-1:0] m);
    logic [L2NK-1:0] idx;
    idx = '0;
    for (int i = NK-1; i >= 0; i--)
      if (m[i]) idx = L2NK'(i);
    return idx;
  endfunction

  state_t            state;
  logic [LCW-1:0]    low_cnt;
  logic [LW-1:0]     next_low, hit_low;
  logic [NK-1:0]     mask;
  logic              start_ok, flush, pop, push, fifo_full;
  logic [KEY_W-1:0]  push_dat;
  logic              unused_start_hi;

  // Top key bits select the kernel, so the caller's copy of them is ignored.
  assign unused_start_hi = ^start_key_i[KEY_W-1:LW];

  assign start_ok = start_i && (state == S_IDLE || state == S_DONE);
  assign flush    = abort_i || start_ok;
  assign pop      = cand_valid_o && cand_ready_i;
  assign push     = (state == S_EMIT) && (mask != '0) && (!fifo_full || pop) && !abort_i;
  assign push_dat = {lowest_idx(mask), hit_low};

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state           <= S_IDLE;
      low_cnt         <= '0;
      next_low        <= '0;
      hit_low         <= '0;
      mask            <= '0;
      dst_challenge_o <= '0;
      dst_response_o  <= '0;
      dst_start_key_o <= '0;
      dst_run_o       <= 1'b0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
    end else if (abort_i) begin
      state     <= S_IDLE;
      mask      <= '0;
      dst_run_o <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            dst_challenge_o <= challenge_i;
            dst_response_o  <= response_i;
            next_low        <= start_key_i[LW-1:0];
            dst_start_key_o <= {{L2NK{1'b0}}, start_key_i[LW-1:0]};
            low_cnt         <= '0;
            state           <= S_LOAD;
            busy_o          <= 1'b1;
            done_o          <= 1'b0;
          end
        end
        // Run held low long enough for the array's run synchroniser to reload.
        S_LOAD: begin
          if (low_cnt == LCW'(LOW_CYCLES - 1)) begin
            state     <= S_RUN;
            dst_run_o <= 1'b1;
          end else begin
            low_cnt <= low_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (dst_key_found_i) begin
            mask      <= dst_kernels_i;
            hit_low   <= dst_key_i;
            state     <= S_EMIT;
            dst_run_o <= 1'b0;
          end else if (dst_key_not_found_i) begin
            state     <= S_DONE;
            dst_run_o <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b1;
          end
        end
        S_EMIT: begin
          if (mask != '0) begin
            if (push) mask <= mask & (mask - 1'b1);
          end else if (&hit_low) begin
            state  <= S_DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else begin
            next_low        <= hit_low + 1'b1;
            dst_start_key_o <= {{L2NK{1'b0}}, hit_low + 1'b1};
            low_cnt         <= '0;
            state           <= S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  dst40_cand_fifo #(
    .W     (KEY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock_i   (clock_i),
    .reset_n_i (reset_n_i),
    .flush     (flush),
    .push      (push),
    .push_dat  (push_dat),
    .pop       (cand_ready_i),
    .pop_dat   (cand_key_o),
    .full      (fifo_full),
    .vld       (cand_valid_o)
  );

`ifdef DST40_SCHED_COUNT_EN
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i)
      cand_count_o <= '0;
    else if (flush)
      cand_count_o <= '0;
    else if (push && cand_count_o != 16'hFFFF)
      cand_count_o <= cand_count_o + 1'b1;
  end
`else
  assign cand_count_o = '0;
`endif

endmodule
